bayer_demosaic: RTL and testbench

BAYER_DEMOSAIC -- requirements
Module: bayer_demosaic

---
 rtl/bayer_demosaic_pkg.sv | 33 +++
 rtl/bayer_demosaic_line_buf.sv | 29 ++
 rtl/bayer_demosaic.sv | 150 +++++++++++++++
 tb/tb_bayer_demosaic.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bayer_demosaic_pkg.sv
// Shared widths, default frame geometry, Bayer phase encoding and the stage-1 beat record.
// Also holds the rounded green average so the demosaic core stays compact.
package bayer_demosaic_pkg;

    localparam int DEF_W = 1920;
    localparam int DEF_H = 1080;
    localparam int PIX_W = 8;
    localparam int RGB_W = 24;

    typedef enum logic [1:0] {
        PH_B  = 2'd0,
        PH_G0 = 2'd1,
        PH_G1 = 2'd2,
        PH_R  = 2'd3
    } phase_t;

    typedef struct packed {
        logic             vld;
        logic             sop;
        logic             eop;
        logic             border;
        phase_t           ph;
        logic [PIX_W-1:0] pix;
    } s1_t;

    // Sum is one bit wider than a pixel, so 255 + 255 + 1 cannot overflow.
    function automatic logic [PIX_W-1:0] g_avg(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        logic [PIX_W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{PIX_W{1'b0}}, 1'b1};
        return s[PIX_W:1];
    endfunction

endpackage

// File: rtl/bayer_demosaic_line_buf.sv
// One-line pixel memory: one write port, one registered read port, read-first on a shared address.
// Latency 1 cycle on read; no reset on contents or read register so it maps onto block RAM.
module line_buf
    import bayer_demosaic_pkg::*;
#(
    parameter  int DEPTH = DEF_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wdat,
    input  logic             re,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rdat
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wdat;
        end
        if (re) begin
            rdat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bayer_demosaic.sv
// 2x2 Bayer-to-RGB demosaic on an Avalon-ST pixel stream; latency 2 enabled advances.
// Backpressure: the whole pipe advances when the output is empty or source_ready, and sink_ready mirrors that.
module bayer_demosaic
    import bayer_demosaic_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int H = DEF_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] sink_data,
    input  logic             sink_sop,
    input  logic             sink_eop,
    input  logic             sink_valid,
    output logic             sink_ready,
    output logic [RGB_W-1:0] source_data,
    output logic             source_sop,
    output logic             source_eop,
    output logic             source_valid,
    input  logic             source_ready
);

    localparam int AW = (W > 1) ? $clog2(W) : 1;

    if (W < 2 || H < 1) begin : g_param_chk
        $error("bayer_demosaic: W must be >= 2 and H >= 1");
    end

    logic             adv;
    logic             acc;
    logic             pix_acc;
    logic [15:0]      x_q, x_d;
    logic [15:0]      y_q, y_d;
    s1_t              s1_q, s1_d;
    logic [PIX_W-1:0] a_q, c_q;
    logic [PIX_W-1:0] above;
    logic [PIX_W-1:0] r_d, g_d, b_d;
    logic [RGB_W-1:0] data_d;

    assign adv        = ~source_valid | source_ready;
    assign sink_ready = adv;
    assign acc        = sink_valid & adv;
    assign pix_acc    = acc & ~sink_sop;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (acc) begin
            if (sink_sop || sink_eop) begin
                x_d = '0;
                y_d = '0;
            end else if (x_q == 16'(W - 1)) begin
                x_d = '0;
                y_d = y_q + 16'd1;
            end else begin
                x_d = x_q + 16'd1;
            end
        end
    end

    always_comb begin
        s1_d = s1_q;
        if (adv) begin
            s1_d.vld    = sink_valid;
            s1_d.sop    = sink_sop;
            s1_d.eop    = sink_eop;
            s1_d.border = (x_q == 16'd0) || (y_q == 16'd0);
            s1_d.ph     = phase_t'({y_q[0], x_q[0]});
            s1_d.pix    = sink_data;
        end
    end

    line_buf #(.DEPTH(W)) u_line_buf (
        .clk     (clk),
        .we      (pix_acc),
        .wr_addr (x_q[AW-1:0]),
        .wdat    (sink_data),
        .re      (pix_acc),
        .rd_addr (x_q[AW-1:0]),
        .rdat    (above)
    );

    // Window: A = a_q (above-left), B = above, C = c_q (left), D = stage-1 pixel.
    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        case (s1_q.ph)
            PH_B: begin
                r_d = a_q;
                g_d = g_avg(above, c_q);
                b_d = s1_q.pix;
            end
            PH_G0: begin
                r_d = above;
                g_d = g_avg(a_q, s1_q.pix);
                b_d = c_q;
            end
            PH_G1: begin
                r_d = c_q;
                g_d = g_avg(a_q, s1_q.pix);
                b_d = above;
            end
            default: begin
                r_d = s1_q.pix;
                g_d = g_avg(above, c_q);
                b_d = a_q;
            end
        endcase
        if (s1_q.sop) begin
            data_d = {16'h0, s1_q.pix};
        end else if (s1_q.border) begin
            data_d = '0;
        end else begin
            data_d = {r_d, g_d, b_d};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q          <= '0;
            y_q          <= '0;
            s1_q         <= '0;
            a_q          <= '0;
            c_q          <= '0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_data  <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            s1_q <= s1_d;
            // Headers must not disturb the left/above-left history of the current line.
            if (adv && s1_q.vld && !s1_q.sop) begin
                a_q <= above;
                c_q <= s1_q.pix;
            end
            if (adv) begin
                source_valid <= s1_q.vld;
                source_sop   <= s1_q.vld & s1_q.sop;
                source_eop   <= s1_q.vld & s1_q.eop;
                if (s1_q.vld) begin
                    source_data <= data_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_bayer_demosaic.sv
// Randomised stimulus against a behavioural image model of the demosaic on a 4-wide frame.
module tb_bayer_demosaic;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  sink_data = '0;
    logic        sink_sop = 1'b0;
    logic        sink_eop = 1'b0;
    logic        sink_valid = 1'b0;
    logic        sink_ready;
    logic [23:0] source_data;
    logic        source_sop;
    logic        source_eop;
    logic        source_valid;
    logic        source_ready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    int rdy_mode = 0;
    int cyc = 0;
    logic [25:0] exp_q[$];
    logic [25:0] obs_q[$];
    int stall_viol = 0;
    int stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [25:0] prev_beat = '0;

    int mx = 0;
    int my = 0;
    logic [7:0] img [int];

    bayer_demosaic #(.W(W), .H(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sink_data    (sink_data),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .source_data  (source_data),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_valid (source_valid),
        .source_ready (source_ready)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        case (rdy_mode)
            0: source_ready = 1'b1;
            1: source_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: source_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        logic [25:0] cur;
        cur = {source_sop, source_eop, source_data};
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!source_valid || cur !== prev_beat)) stall_viol++;
            if (source_valid && source_ready) obs_q.push_back(cur);
            if (source_valid && !source_ready) stall_cnt++;
            prev_stall = source_valid && !source_ready;
            prev_beat  = cur;
        end
    end

    // Reference: every pixel is placed in an image at its raster position and the
    // 2x2 neighbourhood ending at it is classified by Bayer colour.
    task automatic model_beat(input logic sop, input logic eop, input logic [7:0] d);
        logic [23:0] e;
        int r, b, gs, xx, yy, ph;
        if (sop) begin
            exp_q.push_back({1'b1, eop, 16'h0, d});
            mx = 0;
            my = 0;
        end else begin
            img[my * W + mx] = d;
            e = '0;
            if (mx > 0 && my > 0) begin
                r = 0; b = 0; gs = 0;
                for (int dy = -1; dy <= 0; dy++) begin
                    for (int dx = -1; dx <= 0; dx++) begin
                        xx = mx + dx;
                        yy = my + dy;
                        ph = (yy % 2) * 2 + (xx % 2);
                        if (ph == 3) r = int'(img[yy * W + xx]);
                        else if (ph == 0) b = int'(img[yy * W + xx]);
                        else gs += int'(img[yy * W + xx]);
                    end
                end
                e = {8'(r), 8'((gs + 1) / 2), 8'(b)};
            end
            exp_q.push_back({1'b0, eop, e});
            if (eop) begin
                mx = 0;
                my = 0;
            end else if (mx == W - 1) begin
                mx = 0;
                my++;
            end else begin
                mx++;
            end
        end
    endtask

    task automatic send(input logic sop, input logic eop, input logic [7:0] d, input int gap);
        bit ok;
        int t;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        sink_valid = 1'b1;
        sink_sop   = sop;
        sink_eop   = eop;
        sink_data  = d;
        ok = 0;
        t  = 0;
        while (!ok && t < 200) begin
            @(negedge clk);
            if (sink_ready) ok = 1;
            @(posedge clk);
            #1;
            t++;
        end
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        if (ok) begin
            model_beat(sop, eop, d);
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout sink_ready stayed 0 for %0d cycles, required 1", t);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (8) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        stall_viol = 0;
        stall_cnt  = 0;
    endtask

    task automatic send_ramp(input int gap);
        send(1'b1, 1'b0, 8'h00, gap);
        for (int i = 1; i <= 16; i++) send(1'b0, i == 16, 8'(i), gap);
    endtask

    task automatic test_reset();
        n_cmp++; if (source_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", source_valid); end
        n_cmp++; if (source_sop !== 1'b0) begin n_err++; $display("FAIL reset_sop got %b want 0", source_sop); end
        n_cmp++; if (source_eop !== 1'b0) begin n_err++; $display("FAIL reset_eop got %b want 0", source_eop); end
        n_cmp++; if (source_data !== 24'h0) begin n_err++; $display("FAIL reset_data got %h want 000000", source_data); end
        n_cmp++; if (sink_ready !== 1'b1) begin n_err++; $display("FAIL reset_sink_ready got %b want 1", sink_ready); end
    endtask

    task automatic test_ramp();
        rdy_mode = 0;
        clear_queues();
        send_ramp(0);
        wait_drain();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL ramp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ramp_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() > 6) begin
            n_cmp++;
            if (obs_q[6] !== {2'b00, 24'h060401}) begin n_err++; $display("FAIL ramp_pix11 got %h want 0060401", obs_q[6]); end
        end
    endtask

    task automatic test_stall();
        rdy_mode = 1;
        clear_queues();
        send_ramp(0);
        wait_drain();
        rdy_mode = 0;
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (stall_viol !== 0) begin n_err++; $display("FAIL stall_stable got %0d changes want 0", stall_viol); end
        n_cmp++; if (stall_cnt == 0) begin n_err++; $display("FAIL stall_seen got %0d stalled cycles want >0", stall_cnt); end
    endtask

    task automatic test_rounding();
        int interior;
        logic [7:0] v;
        rdy_mode = 0;
        clear_queues();
        send(1'b1, 1'b0, 8'h5a, 0);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                if ((y % 2) == 0 && (x % 2) == 1) v = 8'hff;
                else if ((y % 2) == 1 && (x % 2) == 0) v = 8'hfe;
                else v = 8'($urandom);
                send(1'b0, (y == 3) && (x == 3), v, 0);
            end
        end
        wait_drain();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL round_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        interior = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL round_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
            if (i > 0 && exp_q[i][23:0] != 24'h0) begin
                interior++;
                n_cmp++;
                if (obs_q[i][15:8] !== 8'hff) begin n_err++; $display("FAIL round_g%0d got %h want ff", i, obs_q[i][15:8]); end
            end
        end
        n_cmp++; if (interior != 9) begin n_err++; $display("FAIL round_interior got %0d want 9", interior); end
    endtask

    task automatic test_short_and_midsop();
        rdy_mode = 0;
        clear_queues();
        send(1'b1, 1'b0, 8'h11, 0);
        for (int i = 1; i <= 6; i++) send(1'b0, i == 6, 8'($urandom), 0);
        send(1'b1, 1'b0, 8'h22, 0);
        for (int i = 1; i <= 8; i++) send(1'b0, i == 8, 8'($urandom), 0);
        send(1'b1, 1'b0, 8'h33, 0);
        for (int i = 1; i <= 6; i++) send(1'b0, 1'b0, 8'($urandom), 0);
        send(1'b1, 1'b0, 8'h44, 0);
        for (int i = 1; i <= 8; i++) send(1'b0, i == 8, 8'($urandom), 0);
        wait_drain();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL frame_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL frame_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int n;
        rdy_mode = 2;
        clear_queues();
        for (int f = 0; f < 5; f++) begin
            send(1'b1, 1'b0, 8'($urandom), $urandom_range(0, 2));
            n = $urandom_range(1, 22);
            for (int p = 0; p < n; p++) begin
                if (p != 0 && $urandom_range(0, 14) == 0) send(1'b1, 1'b0, 8'($urandom), 0);
                send(1'b0, p == n - 1, 8'($urandom), $urandom_range(0, 2));
            end
        end
        wait_drain();
        rdy_mode = 0;
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (stall_viol !== 0) begin n_err++; $display("FAIL rand_stable got %0d changes want 0", stall_viol); end
    endtask

    task automatic test_reset_mid();
        rdy_mode = 0;
        clear_queues();
        send(1'b1, 1'b0, 8'h00, 0);
        for (int i = 1; i <= 5; i++) send(1'b0, 1'b0, 8'($urandom), 0);
        rst = 1'b0;
        #1;
        n_cmp++; if (source_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", source_valid); end
        n_cmp++; if (source_data !== 24'h0) begin n_err++; $display("FAIL rstmid_data got %h want 000000", source_data); end
        @(posedge clk);
        #1;
        clear_queues();
        mx = 0;
        my = 0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (sink_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", sink_ready); end
        @(posedge clk);
        #1;
        send_ramp(0);
        wait_drain();
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rstmid_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_ramp();
        test_stall();
        test_rounding();
        test_short_and_midsop();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
